// File: rtl/fpu_shift_pkg.sv
// Shared widths and stage-register layout for the FPU alignment/denormalize shifter.
package fpu_shift_pkg;

    localparam int unsigned MANT_EXT_WIDTH       = 49;
    localparam int unsigned SHIFT_COUNT_WIDTH    = 6;
    localparam int unsigned SHIFT_TAG_WIDTH      = 8;
    localparam int unsigned RESIDUAL_COUNT_WIDTH = SHIFT_COUNT_WIDTH - 3;

    // One beat between shift stages: partially shifted operand, sticky so far,
    // the count bits still to be applied, and the opaque sideband.
    typedef struct packed {
        logic [MANT_EXT_WIDTH-1:0]       operand;
        logic                            sticky;
        logic [RESIDUAL_COUNT_WIDTH-1:0] count;
        logic [SHIFT_TAG_WIDTH-1:0]      tag;
    } shift_beat_t;

endpackage

// File: rtl/align_shift_stage.sv
// Combinational logarithmic right-shift slice: applies BASE_SHIFT << i for each set
// count bit i, OR-ing every bit that leaves the window into the sticky flag.
module align_shift_stage
    import fpu_shift_pkg::*;
#(
    parameter int unsigned WIDTH      = MANT_EXT_WIDTH,
    parameter int unsigned COUNT_BITS = 3,
    parameter int unsigned BASE_SHIFT = 1
) (
    input  logic [WIDTH-1:0]      value,
    input  logic                  sticky_in,
    input  logic [COUNT_BITS-1:0] count,
    output logic [WIDTH-1:0]      value_out,
    output logic                  sticky_out
);

    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] lost_mask;
    logic             sticky;

    // Steps wider than WIDTH need no special case: the mask becomes all ones and
    // the shift clears the value, which is exactly the saturation behaviour.
    always_comb begin
        shifted   = value;
        sticky    = sticky_in;
        lost_mask = '0;
        for (int unsigned i = 0; i < COUNT_BITS; i++) begin
            if (count[i]) begin
                lost_mask = ~({WIDTH{1'b1}} << (BASE_SHIFT << i));
                sticky    = sticky | (|(shifted & lost_mask));
                shifted   = shifted >> (BASE_SHIFT << i);
            end
        end
        value_out  = shifted;
        sticky_out = sticky;
    end

endmodule

// File: rtl/alignment_right_shifter.sv
// Two-stage pipelined right shifter with sticky generation and valid/ready on both
// sides; stage 1 shifts by count[2:0], stage 2 by count[5:3] with saturation.
module alignment_right_shifter
    import fpu_shift_pkg::*;
#(
    // Widths must match fpu_shift_pkg, which defines the stage register layout.
    parameter int unsigned WIDTH       = MANT_EXT_WIDTH,
    parameter int unsigned COUNT_WIDTH = SHIFT_COUNT_WIDTH,
    parameter int unsigned TAG_WIDTH   = SHIFT_TAG_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [COUNT_WIDTH-1:0] in_shift_count,
    input  logic [WIDTH-1:0]       in_operand,
    input  logic [TAG_WIDTH-1:0]   in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_result,
    output logic                   out_sticky,
    output logic [TAG_WIDTH-1:0]   out_tag
);

    shift_beat_t          s1;
    logic                 s1_valid;
    logic                 s2_valid;
    logic [WIDTH-1:0]     s2_result;
    logic                 s2_sticky;
    logic [TAG_WIDTH-1:0] s2_tag;

    logic                 s1_advance;
    logic                 s2_advance;
    logic [WIDTH-1:0]     fine_value;
    logic                 fine_sticky;
    logic [WIDTH-1:0]     coarse_value;
    logic                 coarse_sticky;

    align_shift_stage #(
        .WIDTH      (WIDTH),
        .COUNT_BITS (3),
        .BASE_SHIFT (1)
    ) u_fine_stage (
        .value      (in_operand),
        .sticky_in  (1'b0),
        .count      (in_shift_count[2:0]),
        .value_out  (fine_value),
        .sticky_out (fine_sticky)
    );

    align_shift_stage #(
        .WIDTH      (WIDTH),
        .COUNT_BITS (COUNT_WIDTH - 3),
        .BASE_SHIFT (8)
    ) u_coarse_stage (
        .value      (s1.operand),
        .sticky_in  (s1.sticky),
        .count      (s1.count),
        .value_out  (coarse_value),
        .sticky_out (coarse_sticky)
    );

    assign s2_advance = !s2_valid || out_ready;
    assign s1_advance = !s1_valid || s2_advance;
    assign in_ready   = s1_advance;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            s1        <= '0;
            s2_result <= '0;
            s2_sticky <= 1'b0;
            s2_tag    <= '0;
        end else begin
            if (s2_advance) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_result <= coarse_value;
                    s2_sticky <= coarse_sticky;
                    s2_tag    <= s1.tag;
                end
            end
            if (s1_advance) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1 <= '{operand: fine_value,
                           sticky:  fine_sticky,
                           count:   in_shift_count[COUNT_WIDTH-1:3],
                           tag:     in_tag};
                end
            end
        end
    end

    assign out_valid  = s2_valid;
    assign out_result = s2_result;
    assign out_sticky = s2_sticky;
    assign out_tag    = s2_tag;

endmodule

// File: tb/tb_alignment_right_shifter.sv
// Directed-vector bench for alignment_right_shifter: arithmetic, latency, streaming,
// backpressure and mid-flight reset.
module tb_alignment_right_shifter;
    localparam int W  = 49;
    localparam int CW = 6;
    localparam int TW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] in_shift_count;
    logic [W-1:0]  in_operand;
    logic [TW-1:0] in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_result;
    logic          out_sticky;
    logic [TW-1:0] out_tag;

    int n_compared   = 0;
    int n_mismatched = 0;

    logic [W-1:0]  bt_op  [4];
    logic [CW-1:0] bt_cnt [4];
    logic [TW-1:0] bt_tag [4];
    int next_beat;
    int n_beats;
    logic [TW-1:0] rx_tag [$];
    logic [W-1:0]  rx_res [$];
    logic          rx_stk [$];

    alignment_right_shifter #(
        .WIDTH       (W),
        .COUNT_WIDTH (CW),
        .TAG_WIDTH   (TW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_shift_count (in_shift_count),
        .in_operand     (in_operand),
        .in_tag         (in_tag),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_result     (out_result),
        .out_sticky     (out_sticky),
        .out_tag        (out_tag)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Single beat through an empty pipe with out_ready high.
    task automatic directed(input logic [W-1:0] op, input logic [CW-1:0] cnt,
                            input logic [W-1:0] res, input logic stk, input logic [TW-1:0] tg);
        out_ready      = 1'b1;
        in_valid       = 1'b1;
        in_operand     = op;
        in_shift_count = cnt;
        in_tag         = tg;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check($sformatf("lat_early_%0d", tg), 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        check($sformatf("valid_%0d", tg), 64'(out_valid), 64'd1);
        check($sformatf("result_%0d", tg), 64'(out_result), 64'(res));
        check($sformatf("sticky_%0d", tg), 64'(out_sticky), 64'(stk));
        check($sformatf("tag_%0d", tg), 64'(out_tag), 64'(tg));
        @(posedge clk); #1;
    endtask

    task automatic drive_next();
        if (next_beat < n_beats) begin
            in_valid       = 1'b1;
            in_operand     = bt_op[next_beat];
            in_shift_count = bt_cnt[next_beat];
            in_tag         = bt_tag[next_beat];
        end else begin
            in_valid = 1'b0;
        end
    endtask

    // One clock: observe handshakes mid-cycle, then advance the driver after the edge.
    task automatic run_cycle();
        logic acc;
        logic dlv;
        @(negedge clk);
        acc = in_valid && in_ready;
        dlv = out_valid && out_ready;
        if (dlv) begin
            rx_tag.push_back(out_tag);
            rx_res.push_back(out_result);
            rx_stk.push_back(out_sticky);
        end
        @(posedge clk); #1;
        if (acc) next_beat++;
        drive_next();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset          = 1'b1;
        in_valid       = 1'b0;
        out_ready      = 1'b0;
        in_shift_count = '0;
        in_operand     = '0;
        in_tag         = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_result", 64'(out_result), 64'd0);
        check("rst_sticky", 64'(out_sticky), 64'd0);
        check("rst_tag", 64'(out_tag), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);

        directed(49'h1_0000_0000_0001, 6'd1,  49'h0_8000_0000_0000, 1'b1, 8'd1);
        directed(49'h1_0000_0000_0001, 6'd0,  49'h1_0000_0000_0001, 1'b0, 8'd2);
        directed(49'h1_0000_0000_0000, 6'd48, 49'h1,                1'b0, 8'd3);
        directed(49'h1_0000_0000_0000, 6'd49, 49'h0,                1'b1, 8'd4);
        directed(49'h0,                6'd63, 49'h0,                1'b0, 8'd5);
        directed(49'h0_0000_0000_00FF, 6'd8,  49'h0,                1'b1, 8'd6);
        directed(49'h0_0000_0000_00FF, 6'd4,  49'hF,                1'b1, 8'd7);
        directed(49'h100,              6'd8,  49'h1,                1'b0, 8'd8);
        directed(49'h1_FFFF_FFFF_FFFF, 6'd63, 49'h0,                1'b1, 8'd9);
        directed(49'h1_FFFF_FFFF_FFFF, 6'd47, 49'h3,                1'b1, 8'd10);
        directed(49'h1_2345_6789_ABCD, 6'd16, 49'h0_0001_2345_6789, 1'b1, 8'd11);
        directed(49'hF000,             6'd12, 49'hF,                1'b0, 8'd12);
        directed(49'h1_0000_0000_0000, 6'd56, 49'h0,                1'b1, 8'd13);

        // Back-to-back stream: beat i = ((i<<4)|1) >> 4 -> result i, sticky 1.
        out_ready      = 1'b1;
        in_valid       = 1'b1;
        in_operand     = 49'h1;
        in_shift_count = 6'd4;
        in_tag         = 8'd0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (c >= 1 && c <= 10) begin
                check("stream_valid", 64'(out_valid), 64'd1);
                check("stream_tag", 64'(out_tag), 64'(c - 1));
                check("stream_result", 64'(out_result), 64'(c - 1));
                check("stream_sticky", 64'(out_sticky), 64'd1);
            end else begin
                check("stream_idle", 64'(out_valid), 64'd0);
            end
            if (c + 1 <= 9) begin
                in_operand = (49'(c + 1) << 4) | 49'h1;
                in_tag     = 8'(c + 1);
            end else begin
                in_valid = 1'b0;
            end
        end

        // Backpressure: three beats offered, only two fit while out_ready is low.
        bt_op[0] = 49'h300;              bt_cnt[0] = 6'd9;  bt_tag[0] = 8'hA0;
        bt_op[1] = 49'h1_0000_0000_0000; bt_cnt[1] = 6'd56; bt_tag[1] = 8'hA1;
        bt_op[2] = 49'hABC;              bt_cnt[2] = 6'd4;  bt_tag[2] = 8'hA2;
        next_beat = 0;
        n_beats   = 3;
        out_ready = 1'b0;
        drive_next();
        repeat (5) run_cycle();
        check("bp_accepted", 64'(next_beat), 64'd2);
        check("bp_in_ready", 64'(in_ready), 64'd0);
        check("bp_out_valid", 64'(out_valid), 64'd1);
        check("bp_tag_hold", 64'(out_tag), 64'hA0);
        check("bp_result_hold", 64'(out_result), 64'h1);
        repeat (3) run_cycle();
        check("bp_tag_stable", 64'(out_tag), 64'hA0);
        check("bp_result_stable", 64'(out_result), 64'h1);
        check("bp_sticky_stable", 64'(out_sticky), 64'd1);
        check("bp_none_out", 64'(rx_tag.size()), 64'd0);
        out_ready = 1'b1;
        repeat (6) run_cycle();
        check("bp_all_accepted", 64'(next_beat), 64'd3);
        check("bp_delivered", 64'(rx_tag.size()), 64'd3);
        if (rx_tag.size() >= 3) begin
            check("bp_tag0", 64'(rx_tag[0]), 64'hA0);
            check("bp_tag1", 64'(rx_tag[1]), 64'hA1);
            check("bp_tag2", 64'(rx_tag[2]), 64'hA2);
            check("bp_res0", 64'(rx_res[0]), 64'h1);
            check("bp_res1", 64'(rx_res[1]), 64'h0);
            check("bp_res2", 64'(rx_res[2]), 64'hAB);
            check("bp_stk0", 64'(rx_stk[0]), 64'd1);
            check("bp_stk1", 64'(rx_stk[1]), 64'd1);
            check("bp_stk2", 64'(rx_stk[2]), 64'd1);
        end

        // Reset with two beats held; reset must win over the same-edge drain.
        rx_tag.delete();
        rx_res.delete();
        rx_stk.delete();
        bt_tag[0] = 8'hB0;
        bt_tag[1] = 8'hB1;
        bt_tag[2] = 8'hB2;
        next_beat = 0;
        n_beats   = 3;
        out_ready = 1'b0;
        drive_next();
        repeat (3) run_cycle();
        check("rf_accepted", 64'(next_beat), 64'd2);
        out_ready = 1'b1;
        reset     = 1'b1;
        @(posedge clk); #1;
        reset   = 1'b0;
        n_beats = next_beat;
        drive_next();
        check("rf_out_valid", 64'(out_valid), 64'd0);
        check("rf_result", 64'(out_result), 64'd0);
        check("rf_sticky", 64'(out_sticky), 64'd0);
        check("rf_tag", 64'(out_tag), 64'd0);
        check("rf_in_ready", 64'(in_ready), 64'd1);
        repeat (4) run_cycle();
        check("rf_no_ghosts", 64'(rx_tag.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
